// File: rtl/evm_pkg.sv
// Shared constants, the byte-serializer state type and the frame checksum helper
// for the voting machine's result reporter.
package evm_pkg;

    localparam int NUM_CAND    = 4;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int FRAME_BYTES = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Sum is carried in 10 bits so four full bytes never overflow before truncation.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/evm_uart_byte_tx.sv
// 8N1 byte serializer. Handshake: load is honoured when idle or in the last
// stop-bit cycle (byte_done=1), which lets bytes run back to back with no gap.
module evm_uart_byte_tx
    import evm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done,
    output tx_state_t  state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);

    tx_state_t      next_state;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           bit_end;
    logic           take;

    assign bit_end   = (baud_cnt == LAST_CNT);
    assign byte_done = (state == STOP) && bit_end;
    assign take      = load && ((state == IDLE) || byte_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && (bit_idx == 3'd7)) next_state = STOP;
            STOP:    if (bit_end) next_state = load ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else if (take) begin
            shift    <= byte_in;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                // bit_idx wraps 7 -> 0 on its own as the byte leaves DATA
                if (state == DATA) bit_idx <= bit_idx + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[bit_idx];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/vote_tally_tx.sv
// Result reporter: snapshots the four candidate tallies on request and sends
// A5, c1..c4, checksum as one continuous UART frame.
module vote_tally_tx
    import evm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic             report_req,
    input  logic [CNT_W-1:0] cand1_count,
    input  logic [CNT_W-1:0] cand2_count,
    input  logic [CNT_W-1:0] cand3_count,
    input  logic [CNT_W-1:0] cand4_count,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(255)) return 8'hFF;
        return c[7:0];
    endfunction

    tx_state_t   tx_state;
    logic [7:0]  snap [NUM_CAND];
    logic [7:0]  sat_in [NUM_CAND];
    logic [7:0]  chk_q;
    logic [2:0]  byte_idx;
    logic [7:0]  byte_mux;
    logic        start_frame;
    logic        last_byte;
    logic        next_byte;
    logic        byte_done;
    logic        load;

    assign sat_in[0] = sat8(cand1_count);
    assign sat_in[1] = sat8(cand2_count);
    assign sat_in[2] = sat8(cand3_count);
    assign sat_in[3] = sat8(cand4_count);

    // The serializer never returns to IDLE between bytes, so its state alone says busy.
    assign busy        = (tx_state != IDLE);
    assign start_frame = mode && report_req && (tx_state == IDLE);
    assign last_byte   = (byte_idx == 3'(FRAME_BYTES - 1));
    assign next_byte   = byte_done && !last_byte;
    assign load        = start_frame || next_byte;
    assign done        = byte_done && last_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx <= 3'd0;
            chk_q    <= 8'd0;
            for (int i = 0; i < NUM_CAND; i++) snap[i] <= 8'd0;
        end else if (start_frame) begin
            byte_idx <= 3'd0;
            chk_q    <= frame_checksum(sat_in[0], sat_in[1], sat_in[2], sat_in[3]);
            for (int i = 0; i < NUM_CAND; i++) snap[i] <= sat_in[i];
        end else if (next_byte) begin
            byte_idx <= byte_idx + 3'd1;
        end else if (done) begin
            byte_idx <= 3'd0;
        end
    end

    // Select the byte that follows the one currently finishing.
    always_comb begin
        byte_mux = chk_q;
        if (start_frame) begin
            byte_mux = FRAME_HDR;
        end else begin
            case (byte_idx)
                3'd0:    byte_mux = snap[0];
                3'd1:    byte_mux = snap[1];
                3'd2:    byte_mux = snap[2];
                3'd3:    byte_mux = snap[3];
                default: byte_mux = chk_q;
            endcase
        end
    end

    evm_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .byte_in   (byte_mux),
        .tx        (tx),
        .byte_done (byte_done),
        .state     (tx_state)
    );

endmodule

// File: tb/tb_vote_tally_tx.sv
// Directed bench for vote_tally_tx with CLKS_PER_BIT=4 and 10-bit counts;
// samples on the falling edge, sample k is cycle t+k after the accept cycle t.
module tb_vote_tally_tx;

  localparam int CPB   = 4;
  localparam int CW    = 10;
  localparam int FRAME = 60 * CPB;

  logic          clock = 1'b0;
  logic          reset;
  logic          mode;
  logic          report_req;
  logic [CW-1:0] c1, c2, c3, c4;
  logic [CW-1:0] nc1, nc2, nc3, nc4;
  logic          tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic       tx_samp   [1:600];
  logic       busy_samp [1:600];
  int         busy_cnt, done_cnt, done_at, ones;
  logic [7:0] exp_q [$];

  vote_tally_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .report_req  (report_req),
    .cand1_count (c1),
    .cand2_count (c2),
    .cand3_count (c3),
    .cand4_count (c4),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic request();
    @(negedge clock);
    report_req = 1'b1;
    @(negedge clock);
    report_req = 1'b0;
  endtask

  // Starts at the current falling edge as sample 1.
  task automatic capture(input int n, input int chg_at, input int req_at);
    busy_cnt = 0; done_cnt = 0; done_at = 0; ones = 0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clock);
      tx_samp[k]   = tx;
      busy_samp[k] = busy;
      busy_cnt += int'(busy);
      ones     += int'(tx);
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == chg_at) begin
        c1 = nc1; c2 = nc2; c3 = nc3; c4 = nc4;
      end
      report_req = (k == req_at);
    end
    report_req = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
    exp_q.push_back(b4); exp_q.push_back(b5);
  endtask

  // Each bit is sampled in its second cycle; start and stop bits are checked with the data.
  task automatic decode_check(input string tag, input int base);
    logic [9:0] got;
    logic [7:0] exp;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 10; j++) got[j] = tx_samp[base + b * 40 + j * CPB + 2];
      exp = exp_q.pop_front();
      check($sformatf("%s byte%0d", tag, b), {22'd0, got}, {22'd0, 1'b1, exp, 1'b0});
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b1; report_req = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    nc1 = '0; nc2 = '0; nc3 = '0; nc4 = '0;
    repeat (3) @(negedge clock);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Basic frame: 3+0+7+255 = 265 -> chk 0x09.
    c1 = 10'd3; c2 = 10'd0; c3 = 10'd7; c4 = 10'd255;
    request();
    capture(FRAME + 2, 0, 0);
    push_frame(8'h03, 8'h00, 8'h07, 8'hFF, 8'h09);
    decode_check("basic", 0);
    check("basic busy cycles", busy_cnt, FRAME);
    check("basic done count", done_cnt, 1);
    check("basic done cycle", done_at, FRAME);
    check("basic busy after", {31'd0, busy_samp[FRAME + 1]}, 32'd0);
    check("basic tx first", {31'd0, tx_samp[1]}, 32'd0);

    // Saturation: 300,1,2,1023 -> FF 01 02 FF; FF+01+02+FF = 0x201 -> chk 0x01.
    c1 = 10'd300; c2 = 10'd1; c3 = 10'd2; c4 = 10'd1023;
    request();
    capture(FRAME + 2, 0, 0);
    push_frame(8'hFF, 8'h01, 8'h02, 8'hFF, 8'h01);
    decode_check("sat", 0);
    check("sat done cycle", done_at, FRAME);

    // Result mode off: request ignored.
    mode = 1'b0;
    request();
    capture(300, 0, 0);
    check("mode0 busy", busy_cnt, 0);
    check("mode0 done", done_cnt, 0);
    check("mode0 tx ones", ones, 300);
    mode = 1'b1;

    // Counts change at t+10 and a second request at t+50: original snapshot, one frame.
    c1 = 10'd10; c2 = 10'd20; c3 = 10'd30; c4 = 10'd40;
    nc1 = 10'd1; nc2 = 10'd2; nc3 = 10'd3; nc4 = 10'd4;
    request();
    capture(300, 10, 50);
    push_frame(8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);
    decode_check("snap", 0);
    check("snap busy cycles", busy_cnt, FRAME);
    check("snap done count", done_cnt, 1);

    // Reset at t+100 aborts the frame; a fresh frame then runs complete.
    c1 = 10'd1; c2 = 10'd2; c3 = 10'd3; c4 = 10'd4;
    request();
    repeat (99) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort tx", {31'd0, tx}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    request();
    capture(FRAME + 2, 0, 0);
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    decode_check("fresh", 0);
    check("fresh done cycle", done_at, FRAME);

    // Back to back: request in t+241 gives start bit at t+242.
    // Second frame counts 256,255,0,1 -> FF FF 00 01, chk 0x1FF -> 0xFF.
    c1 = 10'h11; c2 = 10'h22; c3 = 10'h33; c4 = 10'h44;
    nc1 = 10'd256; nc2 = 10'd255; nc3 = 10'd0; nc4 = 10'd1;
    request();
    capture(500, 200, FRAME + 1);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
    push_frame(8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFF);
    decode_check("b2b first", 0);
    decode_check("b2b second", FRAME + 1);
    check("b2b idle gap busy", {31'd0, busy_samp[FRAME + 1]}, 32'd0);
    check("b2b idle gap tx", {31'd0, tx_samp[FRAME + 1]}, 32'd1);
    check("b2b second start", {31'd0, tx_samp[FRAME + 2]}, 32'd0);
    check("b2b busy cycles", busy_cnt, 2 * FRAME);
    check("b2b done count", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
